// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one registered single-precision adder among NREQ requesters.
// Optional subtract select: define FPADD_ARB_SUB_EN to add req_sub and negate operand B per request.

module fpadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, sx, sy, eff_sub;
  logic [7:0]  ex_raw, ey_raw, ex, ey;
  logic [22:0] fx, fy;
  logic [23:0] mx, my;
  logic [8:0]  diff;
  logic [4:0]  sh, lz, shamt;
  logic [53:0] wide;
  logic [26:0] aligned, m;
  logic [27:0] sum;
  logic [8:0]  e_norm;
  logic [7:0]  e_field;
  logic        round_up;
  logic [30:0] mag;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    lzc27 = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc27 = 5'(26 - i);
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Order operands by magnitude so the subtraction below never goes negative
    swap   = (b[30:0] > a[30:0]);
    sx     = swap ? b[31] : a[31];
    sy     = swap ? a[31] : b[31];
    ex_raw = swap ? b[30:23] : a[30:23];
    ey_raw = swap ? a[30:23] : b[30:23];
    fx     = swap ? b[22:0] : a[22:0];
    fy     = swap ? a[22:0] : b[22:0];
    mx     = {ex_raw != 8'd0, fx};
    my     = {ey_raw != 8'd0, fy};
    ex     = (ex_raw == 8'd0) ? 8'd1 : ex_raw;
    ey     = (ey_raw == 8'd0) ? 8'd1 : ey_raw;

    diff    = {1'b0, ex} - {1'b0, ey};
    sh      = (diff > 9'd27) ? 5'd27 : diff[4:0];
    wide    = {my, 3'b000, 27'd0} >> sh;
    aligned = {wide[53:28], wide[27] | (|wide[26:0])};

    eff_sub = sx ^ sy;
    if (eff_sub)
      sum = {1'b0, mx, 3'b000} - {1'b0, aligned};
    else
      sum = {1'b0, mx, 3'b000} + {1'b0, aligned};

    lz    = lzc27(sum[26:0]);
    shamt = 5'd0;
    if (sum[27]) begin
      m      = {sum[27:2], sum[1] | sum[0]};
      e_norm = {1'b0, ex} + 9'd1;
    end else begin
      // Stop normalising at the minimum exponent; the result then becomes subnormal
      if ({3'b000, lz} < (ex - 8'd1))
        shamt = lz;
      else
        shamt = 5'(ex - 8'd1);
      m      = sum[26:0] << shamt;
      e_norm = {1'b0, ex} - {4'b0000, shamt};
    end

    e_field  = m[26] ? e_norm[7:0] : 8'd0;
    round_up = m[2] & (m[1] | m[0] | m[3]);
    mag      = {e_field, m[25:3]} + {30'd0, round_up};
    if (e_norm >= 9'd255)
      mag = {8'hFF, 23'd0};

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31])))
      s = 32'h7FC0_0000;
    else if (a_inf)
      s = a;
    else if (b_inf)
      s = b;
    else if (sum == 28'd0)
      s = {sx & sy, 31'd0};
    else
      s = {sx, mag};
  end

endmodule

module fpadd_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
`ifdef FPADD_ARB_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_s,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready
);

  logic           v1, v2;
  logic [31:0]    a1, b1, s2, b_in, sum;
  logic [IDW-1:0] id1, id2, ptr, win;
  logic           any_valid, stall, load1, xfer;
  int             j;

  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ)
        j = j - NREQ;
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        win       = j[IDW-1:0];
      end
    end
  end

  assign stall = v2 & ~rsp_ready;
  assign load1 = ~stall | ~v1;
  assign xfer  = any_valid & load1;

  always_comb begin
    req_ready = '0;
    if (xfer)
      req_ready[win] = 1'b1;
  end

`ifdef FPADD_ARB_SUB_EN
  logic sub1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sub1 <= 1'b0;
    else if (load1 && xfer)
      sub1 <= req_sub[win];
  end

  assign b_in = {b1[31] ^ sub1, b1[30:0]};
`else
  assign b_in = b1;
`endif

  fpadd u_fpadd (
    .a (a1),
    .b (b_in),
    .s (sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      id1 <= '0;
      v2  <= 1'b0;
      s2  <= '0;
      id2 <= '0;
      ptr <= '0;
    end else begin
      if (load1) begin
        v1 <= xfer;
        if (xfer) begin
          a1  <= req_a[int'(win)*32 +: 32];
          b1  <= req_b[int'(win)*32 +: 32];
          id1 <= win;
        end
      end
      if (!stall) begin
        v2  <= v1;
        s2  <= sum;
        id2 <= id1;
      end
      if (xfer)
        ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

  assign rsp_valid = v2;
  assign rsp_s     = s2;
  assign rsp_id    = id2;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed self-checking bench for fpadd_arbiter: reset, add, round-robin, back-pressure, wrap.
module tb_fpadd_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
`ifdef FPADD_ARB_SUB_EN
  logic [3:0]   req_sub;
`endif
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_s;
  logic [1:0]   rsp_id;
  logic         rsp_ready;

  int checks;
  int failures;

  logic [31:0] op_a  [4];
  logic [31:0] op_b  [4];
  logic [31:0] exp_s [4];

  fpadd_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef FPADD_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_s     (rsp_s),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'($urandom());
      req_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
      rsp_ready = 1'($urandom());
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_s !== 32'd0 || rsp_id !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got v=%b s=%h id=%0d required v=0 s=0 id=0",
                 c, rsp_valid, rsp_s, rsp_id);
      end
    end
    req_valid = 4'b1100;
    reset     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL reset_first_grant got=%b required=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_single_add();
    do_reset();
    op_a[0] = 32'h3F80_0000;
    op_b[0] = 32'h4000_0000;
    load_ops();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL add_grant got=%b required=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_early_valid got=%b required=0", rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_s !== 32'h4040_0000 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL add_result got v=%b s=%h id=%0d required v=1 s=40400000 id=0",
               rsp_valid, rsp_s, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] e_rdy;
    int         pid;
    do_reset();
    load_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k > 0)
        @(negedge clk);
      #1;
      e_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== e_rdy) begin
        failures++;
        $display("FAIL rr_grant cycle=%0d got=%b required=%b", k, req_ready, e_rdy);
      end
      checks++;
      if (k < 2) begin
        if (rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL rr_idle cycle=%0d got v=%b required v=0", k, rsp_valid);
        end
      end else begin
        pid = (k - 2) % 4;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(pid) || rsp_s !== exp_s[pid]) begin
          failures++;
          $display("FAIL rr_rsp cycle=%0d got v=%b id=%0d s=%h required v=1 id=%0d s=%h",
                   k, rsp_valid, rsp_id, rsp_s, pid, exp_s[pid]);
        end
      end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_pressure();
    do_reset();
    load_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_grant0 got=%b required=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_grant1 got rdy=%b v=%b required rdy=0010 v=0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      if (c > 0)
        @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_s !== exp_s[0]) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got rdy=%b v=%b id=%0d s=%h required rdy=0000 v=1 id=0 s=%h",
                 c, req_ready, rsp_valid, rsp_id, rsp_s, exp_s[0]);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || rsp_id !== 2'd0 || rsp_s !== exp_s[0]) begin
      failures++;
      $display("FAIL bp_release got rdy=%b id=%0d s=%h required rdy=0100 id=0 s=%h",
               req_ready, rsp_id, rsp_s, exp_s[0]);
    end
    for (int r = 1; r < 3; r++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(r) || rsp_s !== exp_s[r]) begin
        failures++;
        $display("FAIL bp_drain idx=%0d got v=%b id=%0d s=%h required v=1 id=%0d s=%h",
                 r, rsp_valid, rsp_id, rsp_s, r, exp_s[r]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup got v=%b id=%0d required v=0", rsp_valid, rsp_id);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    load_ops();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_setup got=%b required=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_first got=%b required=0010", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0100 || rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_second got rdy=%b v=%b id=%0d required rdy=0100 v=1 id=2",
               req_ready, rsp_valid, rsp_id);
    end
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL wrap_ptr_end got rdy=%b id=%0d required rdy=1000 id=1", req_ready, rsp_id);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_id !== 2'd2 || rsp_s !== exp_s[2]) begin
      failures++;
      $display("FAIL wrap_rsp2 got id=%0d s=%h required id=2 s=%h", rsp_id, rsp_s, exp_s[2]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    load_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_s !== exp_s[0]) begin
      failures++;
      $display("FAIL flight_pre got v=%b s=%h required v=1 s=%h", rsp_valid, rsp_s, exp_s[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_s !== 32'd0 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL flight_async_clear got v=%b s=%h id=%0d required v=0 s=0 id=0",
               rsp_valid, rsp_s, rsp_id);
    end
    @(negedge clk);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL flight_ptr_cleared got=%b required=0001", req_ready);
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL flight_discard cycle=%0d got v=%b required v=0", c, rsp_valid);
      end
    end
  endtask

`ifdef FPADD_ARB_SUB_EN
  task automatic test_sub();
    do_reset();
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'h3F80_0000;
    req_sub     = 4'b0001;
    req_valid   = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_s !== 32'h4000_0000) begin
      failures++;
      $display("FAIL sub_result got v=%b s=%h required v=1 s=40000000", rsp_valid, rsp_s);
    end
    req_sub = 4'b0000;
    @(negedge clk);
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef FPADD_ARB_SUB_EN
    req_sub   = 4'b0000;
`endif
    // 1+2=3, 2+2=4, 1+(-1)=+0, -2.5+1=-1.5
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; exp_s[0] = 32'h4040_0000;
    op_a[1] = 32'h4000_0000; op_b[1] = 32'h4000_0000; exp_s[1] = 32'h4080_0000;
    op_a[2] = 32'h3F80_0000; op_b[2] = 32'hBF80_0000; exp_s[2] = 32'h0000_0000;
    op_a[3] = 32'hC020_0000; op_b[3] = 32'h3F80_0000; exp_s[3] = 32'hBFC0_0000;
    @(negedge clk);

    test_reset();
    test_single_add();
    test_round_robin();
    test_back_pressure();
    test_wrap_skip();
    test_reset_in_flight();
`ifdef FPADD_ARB_SUB_EN
    test_sub();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

- Shares one single-precision `fpadd` instance between `NREQ` requesters.
- Arbitration is round-robin over valid/ready request ports.
- Operands and results are registered around the combinational adder.
- Results return on one response bus tagged with the requester index. Sits between the ALU issue logic and the FP adder datapath.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester-index width, equal to ceil(log2(NREQ))
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `req_valid`  in  NREQ  per-requester request valid
- `req_a`  in  NREQ*32  packed operand A; requester i uses bits [32i+31:32i]
- `req_b`  in  NREQ*32  packed operand B, same packing
- `req_sub`  in  NREQ  subtract select; present only with `FPADD_ARB_SUB_EN`
- `req_ready`  out  NREQ  one-hot grant; a transfer happens when valid and ready are both 1
- `rsp_valid`  out  1  result valid
- `rsp_s`  out  32  result from `fpadd`
- `rsp_id`  out  IDW  index of the requester that owns `rsp_s`
- `rsp_ready`  in  1  consumer accepts the result

## Operation
- **Pipeline stages:**
  - S1 is an operand register: `v1`, `a1`, `b1`, `id1`.
  - The `fpadd` instance is combinational on `a1` and `b1`.
  - S2 is a result register: `v2`, `s2`, `id2`. It drives `rsp_valid`, `rsp_s` and `rsp_id`.
- **Stall:** `stall = v2 & ~rsp_ready`.
  - S2 loads when `~stall`.
  - S1 loads when `~stall`, or when `~v1`.
- **Arbiter:**
  - Round-robin pointer `ptr` of width IDW. Its reset value is 0.
  - The search starts at `ptr` and wraps upward through NREQ-1 and back to 0. The first index with `req_valid` set wins.
  - `req_ready[i]` = (i is the winner) & S1-load-enable. It is combinational and never has more than one bit set.
  - On a transfer to requester i, `ptr` becomes (i+1) mod NREQ.
  - With no transfer, `ptr` holds.
- **Requester rule:** `req_a`, `req_b` (and `req_sub`) must stay stable while `req_valid` is high and the request has not been granted. A requester may drop `req_valid` at any time without error; its request is simply not issued.
- **S1 load:**
  - With a transfer: `v1` = 1, and `a1`, `b1`, `id1` capture the winner's operands and index.
  - With no transfer: `v1` = 0.
- **S2 load:** `v2` = `v1`, `s2` = fpadd(`a1`, `b1`), `id2` = `id1`.
- **Ordering:** results leave in grant order. No request is lost or duplicated under back-pressure.
- **Reset:**
  - Asynchronous, active-low. Clears `v1`, `v2` and `ptr`, and zeroes `a1`, `b1`, `s2`, `id1`, `id2`.
  - A request in flight when reset asserts is discarded.
  - Output values during and after reset: `rsp_valid`=0, `rsp_s`=0, `rsp_id`=0. `req_ready` is combinational and may be nonzero while reset is low.

## Timing
- **Latency:** if a request is granted in cycle N and `rsp_ready` is 1, its result has `rsp_valid` = 1 in cycle N+2.
- **Throughput:** one operation per cycle while `rsp_ready` stays 1.
- **Capacity:** when `rsp_ready` is held 0, at most 2 operations can be outstanding (S1 and S2). `req_ready` is all zeros while S1 holds an operation and S2 is stalled.
- **Response hold:** `rsp_s` and `rsp_id` stay stable while `rsp_valid=1` and `rsp_ready=0`.
- **Simultaneous events:** `rsp_ready` rising in the same cycle that S1 is full lets S1 move to S2 and a new grant happen in that same cycle.
- **Single requester:** one continuously valid requester is granted every cycle.

## Configuration
- Macro: `FPADD_ARB_SUB_EN`.
- **With the macro defined:**
  - The `req_sub` port exists.
  - S1 also captures `sub1`.
  - The adder's B input is `{b1[31]^sub1, b1[30:0]}`, so the result is A−B when `req_sub` is 1.
- **Without the macro:**
  - The `req_sub` port and `sub1` are absent.
  - The B input is `b1` unchanged, so the block only adds.

## Test plan
- **Reset:** hold `reset`=0 with random inputs. Required response: `rsp_valid`=0, `rsp_s`=0 and `rsp_id`=0. After release, the first grant goes to the lowest-index valid requester.
- **Single add:** req0 sends A=0x3F800000, B=0x40000000 at cycle N. Required response: `rsp_valid` at N+2 with `rsp_s`=0x40400000 and `rsp_id`=0.
- **Round-robin:** all 4 requesters held valid, `rsp_ready`=1. Required response: grants in order 0,1,2,3,0,… one per cycle, and `rsp_id` follows the same order two cycles later.
- **Back-pressure:** 3 requests issued while `rsp_ready`=0. Required response:
  - Only 2 are accepted.
  - `req_ready`=0 afterwards, and `rsp_s` is held.
  - After releasing `rsp_ready`, all 3 results appear in order with no loss or duplicate.
- **Wrap and skip:** `ptr`=3 with only req1 and req2 valid. Required response: req1 is granted next, then req2, and `ptr` ends at 3.
- **Subtract (macro defined):** `req_sub`=1 with A=0x40400000, B=0x3F800000. Required response: `rsp_s`=0x40000000.
